// File: rtl/issue_ctrl_pkg.sv
// Shared decode-stage types: architectural widths, issue FSM states and the
// scoreboard vector type.
package issue_ctrl_pkg;

    localparam int cXLEN     = 32;
    localparam int cRegNum   = 32;
    localparam int cRegAddrW = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } tIssueState;

    typedef logic [cRegNum-1:0] tScoreboard;

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// Pending-write scoreboard for long-latency loads, with a writeback-aware
// hazard lookup on the two source ports.
module issue_ctrl_scoreboard
    import issue_ctrl_pkg::*;
#(
    parameter int cRegNum = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_dv,
    input  logic [cRegAddrW-1:0] wb_addr,
    input  logic                 set_en,
    input  logic [cRegAddrW-1:0] set_addr,
    input  logic [cRegAddrW-1:0] rs1_addr,
    input  logic [cRegAddrW-1:0] rs2_addr,
    input  logic                 use_rs1,
    input  logic                 use_rs2,
    output logic [cRegNum-1:0]   busy,
    output logic                 haz
);

    logic [cRegNum-1:0] busy_next;
    logic               haz_rs1;
    logic               haz_rs2;

    // A writeback landing this cycle satisfies the reader without a bubble.
    assign haz_rs1 = use_rs1 && (rs1_addr != '0) && busy[rs1_addr]
                     && !(wb_dv && (wb_addr == rs1_addr));
    assign haz_rs2 = use_rs2 && (rs2_addr != '0) && busy[rs2_addr]
                     && !(wb_dv && (wb_addr == rs2_addr));
    assign haz     = haz_rs1 || haz_rs2;

    // NOTE: busy_next takes a full default first so no path leaves it unassigned (no latch).
    always_comb begin
        busy_next = busy;
        if (wb_dv)
            busy_next[wb_addr] = 1'b0;
        // Applied after the clear so a same-cycle issue to the same register wins.
        if (set_en && (set_addr != '0))
            busy_next[set_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_next;
    end

endmodule

// File: rtl/issue_ctrl.sv
// Decode-stage issue control: RAW stall via the scoreboard, issue to execute,
// and pipe flush plus PC redirect on a taken branch from execute.
module issue_ctrl #(
    parameter int cycleNum = 2,
    parameter int cRegNum  = issue_ctrl_pkg::cRegNum
) (
    input  logic                            iClk,
    input  logic                            iRst,
    input  logic                            iDecDv,
    input  logic [4:0]                      iRs1Addr,
    input  logic [4:0]                      iRs2Addr,
    input  logic [4:0]                      iRdAddr,
    input  logic                            iUseRs1,
    input  logic                            iUseRs2,
    input  logic                            iWrRd,
    input  logic                            iIsLoad,
    input  logic                            iExRdy,
    input  logic                            iWbDv,
    input  logic [4:0]                      iWbAddr,
    input  logic                            iBrTaken,
    input  logic [issue_ctrl_pkg::cXLEN-1:0] iBrTarget,
    output logic                            oIssueDv,
    output logic                            oStall,
    output logic                            oFlushPipe,
    output logic                            oPcRedirDv,
    output logic [issue_ctrl_pkg::cXLEN-1:0] oPcRedir,
    output logic [cRegNum-1:0]              oBusy
);

    import issue_ctrl_pkg::*;

    localparam int cCntW = (cycleNum < 2) ? 1 : $clog2(cycleNum + 1);

    tIssueState       state;
    logic [cCntW-1:0] flush_cnt;
    logic             sb_haz;
    logic             haz;
    logic             run_phase;
    logic             set_en;

    // A taken branch kills whatever sits in decode this cycle.
    assign run_phase = (state != FLUSH) && !iBrTaken;
    assign haz       = iDecDv && sb_haz;
    assign oIssueDv  = run_phase && iDecDv && !haz && iExRdy;
    assign oStall    = run_phase && iDecDv && (haz || !iExRdy);
    assign set_en    = oIssueDv && iIsLoad && iWrRd;

    issue_ctrl_scoreboard #(
        .cRegNum (cRegNum)
    ) u_scoreboard (
        .clk      (iClk),
        .rst      (iRst),
        .wb_dv    (iWbDv),
        .wb_addr  (iWbAddr),
        .set_en   (set_en),
        .set_addr (iRdAddr),
        .rs1_addr (iRs1Addr),
        .rs2_addr (iRs2Addr),
        .use_rs1  (iUseRs1),
        .use_rs2  (iUseRs2),
        .busy     (oBusy),
        .haz      (sb_haz)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state      <= RUN;
            flush_cnt  <= '0;
            oFlushPipe <= 1'b0;
            oPcRedirDv <= 1'b0;
            oPcRedir   <= '0;
        end else if (iBrTaken) begin
            state      <= FLUSH;
            flush_cnt  <= cCntW'(cycleNum);
            oFlushPipe <= 1'b1;
            oPcRedirDv <= 1'b1;
            oPcRedir   <= iBrTarget;
        end else begin
            oPcRedirDv <= 1'b0;
            case (state)
                RUN, STALL: begin
                    state      <= oStall ? STALL : RUN;
                    oFlushPipe <= 1'b0;
                end
                FLUSH: begin
                    // Leaving on a count of 1 yields exactly cycleNum flush cycles.
                    if (flush_cnt <= cCntW'(1)) begin
                        state      <= RUN;
                        flush_cnt  <= '0;
                        oFlushPipe <= 1'b0;
                    end else begin
                        flush_cnt  <= flush_cnt - cCntW'(1);
                    end
                end
                default: begin
                    state      <= RUN;
                    flush_cnt  <= '0;
                    oFlushPipe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: RAW stall and bypass, x0 handling, set-wins,
// execute back-pressure, branch flush/redirect and reset during flush.
module tb_issue_ctrl;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iDecDv;
    logic [4:0]  iRs1Addr;
    logic [4:0]  iRs2Addr;
    logic [4:0]  iRdAddr;
    logic        iUseRs1;
    logic        iUseRs2;
    logic        iWrRd;
    logic        iIsLoad;
    logic        iExRdy;
    logic        iWbDv;
    logic [4:0]  iWbAddr;
    logic        iBrTaken;
    logic [31:0] iBrTarget;
    logic        oIssueDv;
    logic        oStall;
    logic        oFlushPipe;
    logic        oPcRedirDv;
    logic [31:0] oPcRedir;
    logic [31:0] oBusy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 iClk = ~iClk;

    issue_ctrl #(
        .cycleNum (2),
        .cRegNum  (32)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iDecDv     (iDecDv),
        .iRs1Addr   (iRs1Addr),
        .iRs2Addr   (iRs2Addr),
        .iRdAddr    (iRdAddr),
        .iUseRs1    (iUseRs1),
        .iUseRs2    (iUseRs2),
        .iWrRd      (iWrRd),
        .iIsLoad    (iIsLoad),
        .iExRdy     (iExRdy),
        .iWbDv      (iWbDv),
        .iWbAddr    (iWbAddr),
        .iBrTaken   (iBrTaken),
        .iBrTarget  (iBrTarget),
        .oIssueDv   (oIssueDv),
        .oStall     (oStall),
        .oFlushPipe (oFlushPipe),
        .oPcRedirDv (oPcRedirDv),
        .oPcRedir   (oPcRedir),
        .oBusy      (oBusy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic sample();
        @(negedge iClk);
    endtask

    task automatic idle();
        iDecDv    = 1'b0;
        iRs1Addr  = 5'd0;
        iRs2Addr  = 5'd0;
        iRdAddr   = 5'd0;
        iUseRs1   = 1'b0;
        iUseRs2   = 1'b0;
        iWrRd     = 1'b0;
        iIsLoad   = 1'b0;
        iExRdy    = 1'b1;
        iWbDv     = 1'b0;
        iWbAddr   = 5'd0;
        iBrTaken  = 1'b0;
        iBrTarget = 32'h0;
    endtask

    task automatic load_to(input logic [4:0] rd);
        idle();
        iDecDv  = 1'b1;
        iRdAddr = rd;
        iWrRd   = 1'b1;
        iIsLoad = 1'b1;
    endtask

    task automatic read_rs1(input logic [4:0] rs);
        idle();
        iDecDv   = 1'b1;
        iRs1Addr = rs;
        iUseRs1  = 1'b1;
    endtask

    initial begin
        idle();
        iRst = 1'b1;
        tick();
        tick();
        sample();
        check("rst_busy",    oBusy,      32'h0);
        check("rst_issue",   oIssueDv,   32'h0);
        check("rst_stall",   oStall,     32'h0);
        check("rst_flush",   oFlushPipe, 32'h0);
        check("rst_redirdv", oPcRedirDv, 32'h0);
        check("rst_redir",   oPcRedir,   32'h0);
        tick();
        iRst = 1'b0;

        // Load x5, then a reader of x5 stalls until the writeback bypass.
        load_to(5'd5);
        sample();
        check("ld5_issue", oIssueDv, 32'h1);
        tick();
        read_rs1(5'd5);
        sample();
        check("raw_busy",  oBusy,    32'h0000_0020);
        check("raw_stall", oStall,   32'h1);
        check("raw_issue", oIssueDv, 32'h0);
        tick();
        sample();
        check("raw_stall2", oStall, 32'h1);
        tick();
        iWbDv   = 1'b1;
        iWbAddr = 5'd5;
        sample();
        check("byp_issue", oIssueDv, 32'h1);
        check("byp_stall", oStall,   32'h0);
        tick();
        idle();
        sample();
        check("byp_busy_clr", oBusy, 32'h0);

        // Load to x0 never marks busy; a reader of x0 never stalls.
        load_to(5'd0);
        tick();
        read_rs1(5'd0);
        iUseRs2 = 1'b1;
        sample();
        check("x0_issue", oIssueDv, 32'h1);
        check("x0_stall", oStall,   32'h0);
        check("x0_busy",  oBusy,    32'h0);
        tick();

        // Same-cycle writeback and new load to x7: the set wins.
        load_to(5'd7);
        tick();
        load_to(5'd7);
        iWbDv   = 1'b1;
        iWbAddr = 5'd7;
        sample();
        check("x7_busy_pre", oBusy,    32'h0000_0080);
        check("x7_issue",    oIssueDv, 32'h1);
        tick();
        iWbDv   = 1'b1;
        iWbAddr = 5'd7;
        iDecDv  = 1'b0;
        sample();
        check("x7_set_wins", oBusy, 32'h0000_0080);
        tick();
        idle();
        iWbDv   = 1'b1;
        iWbAddr = 5'd9;
        sample();
        check("x7_cleared", oBusy, 32'h0);
        tick();
        idle();
        sample();
        check("wb_nonbusy", oBusy, 32'h0);

        // Execute back-pressure without a hazard.
        read_rs1(5'd3);
        iExRdy = 1'b0;
        sample();
        check("exrdy0_stall", oStall,   32'h1);
        check("exrdy0_issue", oIssueDv, 32'h0);
        tick();
        iExRdy = 1'b1;
        sample();
        check("exrdy1_issue", oIssueDv, 32'h1);
        check("exrdy1_stall", oStall,   32'h0);
        tick();

        // Taken branch while stalled on x5.
        load_to(5'd5);
        tick();
        read_rs1(5'd5);
        tick();
        sample();
        check("br_pre_stall", oStall, 32'h1);
        iBrTaken  = 1'b1;
        iBrTarget = 32'h0000_1000;
        #1;
        check("br_cyc_issue", oIssueDv, 32'h0);
        tick();
        iBrTaken  = 1'b0;
        iBrTarget = 32'h0;
        sample();
        check("f1_redirdv", oPcRedirDv, 32'h1);
        check("f1_redir",   oPcRedir,   32'h0000_1000);
        check("f1_flush",   oFlushPipe, 32'h1);
        check("f1_issue",   oIssueDv,   32'h0);
        check("f1_stall",   oStall,     32'h0);
        tick();
        sample();
        check("f2_redirdv", oPcRedirDv, 32'h0);
        check("f2_flush",   oFlushPipe, 32'h1);
        check("f2_issue",   oIssueDv,   32'h0);
        check("f2_redir",   oPcRedir,   32'h0000_1000);
        tick();
        sample();
        check("post_flush",  oFlushPipe, 32'h0);
        check("post_busy",   oBusy,      32'h0000_0020);
        check("post_stall",  oStall,     32'h1);

        // Second branch, a reload during FLUSH, then reset mid-flush.
        idle();
        iBrTaken  = 1'b1;
        iBrTarget = 32'h0000_2000;
        tick();
        iBrTarget = 32'h0000_3000;
        sample();
        check("b2_redir",  oPcRedir,   32'h0000_2000);
        check("b2_flush",  oFlushPipe, 32'h1);
        tick();
        iBrTaken  = 1'b0;
        iBrTarget = 32'h0;
        sample();
        check("rl_redirdv", oPcRedirDv, 32'h1);
        check("rl_redir",   oPcRedir,   32'h0000_3000);
        check("rl_busy",    oBusy,      32'h0000_0020);
        iRst = 1'b1;
        tick();
        sample();
        check("mr_busy",    oBusy,      32'h0);
        check("mr_flush",   oFlushPipe, 32'h0);
        check("mr_redirdv", oPcRedirDv, 32'h0);
        check("mr_redir",   oPcRedir,   32'h0);
        check("mr_issue",   oIssueDv,   32'h0);
        check("mr_stall",   oStall,     32'h0);
        tick();
        iRst = 1'b0;
        read_rs1(5'd5);
        sample();
        check("mr_run_issue", oIssueDv, 32'h1);
        tick();
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
